// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin arbiter in front of a one-bit-per-cycle
// logical shifter, returning each result on a valid/ready response channel
// tagged with the owning requester.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [AW-1:0]    req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [AW-1:0]    req1_amt,
  input  logic             req1_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [AW-1:0]    cnt, cnt_next;
  logic             dir, dir_next;
  logic             id, id_next;
  logic             last_id, last_id_next;
  logic             grant;
  logic             in_idle;

  assign in_idle = (state == IDLE);

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_id;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readys are gated by rst_n so they drop the instant reset is asserted.
  assign req0_ready = rst_n && in_idle && !grant && req0_valid;
  assign req1_ready = rst_n && in_idle &&  grant && req1_valid;

  // Next-state and datapath update for the IDLE / SHIFT / DONE sequence.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    cnt_next     = cnt;
    dir_next     = dir;
    id_next      = id;
    last_id_next = last_id;
    case (state)
      IDLE: begin
        if (req0_ready) begin
          acc_next     = req0_data;
          cnt_next     = req0_amt;
          dir_next     = req0_dir;
          id_next      = 1'b0;
          last_id_next = 1'b0;
          state_next   = (req0_amt != '0) ? SHIFT : DONE;
        end else if (req1_ready) begin
          acc_next     = req1_data;
          cnt_next     = req1_amt;
          dir_next     = req1_dir;
          id_next      = 1'b1;
          last_id_next = 1'b1;
          state_next   = (req1_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        // Amounts beyond WIDTH simply keep shifting zeros; no early exit.
        acc_next = dir ? (acc >> 1) : (acc << 1);
        cnt_next = cnt - AW'(1);
        if (cnt == AW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      dir     <= 1'b0;
      id      <= 1'b0;
      last_id <= 1'b1;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      dir     <= dir_next;
      id      <= id_next;
      last_id <= last_id_next;
    end
  end

  assign rsp_valid = (state == DONE);
  assign rsp_data  = rsp_valid ? acc : '0;
  assign rsp_id    = rsp_valid & id;
  assign busy      = !in_idle;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: shifts, zero and over-range amounts,
// round-robin order, response backpressure and reset mid-shift.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_dir;
  logic [3:0] req0_data;
  logic [2:0] req0_amt;
  logic       req1_valid, req1_ready, req1_dir;
  logic [3:0] req1_data;
  logic [2:0] req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [3:0] rsp_data;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.WIDTH(4), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [3:0] d, input logic i);
    chk({tag, ".valid"}, {7'd0, rsp_valid}, {7'd0, v});
    chk({tag, ".data"},  {4'd0, rsp_data},  {4'd0, d});
    chk({tag, ".id"},    {7'd0, rsp_id},    {7'd0, i});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy0"}, {7'd0, req0_ready}, {7'd0, r0});
    chk({tag, ".rdy1"}, {7'd0, req1_ready}, {7'd0, r1});
  endtask

  task automatic chk_busy(input string tag, input logic b);
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 4'hF; req0_amt = 3'd0; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 4'hF; req1_amt = 3'd0; req1_dir = 1'b0;

    // Reset: outputs zero, readys held low despite valid requests
    step(); step();
    chk_rsp("rst", 1'b0, 4'b0000, 1'b0);
    chk_rdy("rst", 1'b0, 1'b0);
    chk_busy("rst", 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk_busy("idle", 1'b0);
    $display("reset done");

    // Single left shift: 1011 << 1 = 0110, id 0
    req0_valid = 1'b1; req0_data = 4'b1011; req0_amt = 3'd1; req0_dir = 1'b0;
    #1 chk_rdy("lsh.T", 1'b1, 1'b0);
    step(); req0_valid = 1'b0; #1;
    chk_busy("lsh.T1", 1'b1);
    chk_rsp("lsh.T1", 1'b0, 4'b0000, 1'b0);
    step();
    chk_busy("lsh.T2", 1'b1);
    chk_rsp("lsh.T2", 1'b1, 4'b0110, 1'b0);
    step();
    chk_busy("lsh.T3", 1'b0);
    $display("left shift: data=%b id=%0d", 4'b0110, 0);

    // Right shift by 2 from requester 1: 1011 >> 2 = 0010
    req1_valid = 1'b1; req1_data = 4'b1011; req1_amt = 3'd2; req1_dir = 1'b1;
    #1 chk_rdy("rsh.T", 1'b0, 1'b1);
    step(); req1_valid = 1'b0; #1;
    chk_rsp("rsh.T1", 1'b0, 4'b0000, 1'b0);
    step();
    chk_rsp("rsh.T2", 1'b0, 4'b0000, 1'b0);
    step();
    chk_rsp("rsh.T3", 1'b1, 4'b0010, 1'b1);
    step();
    $display("right shift: data=%b id=%0d", 4'b0010, 1);

    // Round-robin with both continuously valid: order 0,1,0,1
    req0_valid = 1'b1; req0_data = 4'b0001; req0_amt = 3'd1; req0_dir = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b1000; req1_amt = 3'd1; req1_dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = i[0];
      #1 chk_rdy("rr.acc", !e, e);
      step();
      chk_rdy("rr.shift", 1'b0, 1'b0);
      step();
      chk_rdy("rr.done", 1'b0, 1'b0);
      chk_rsp("rr.done", 1'b1, e ? 4'b0100 : 4'b0010, e);
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      step();
      $display("round-robin accept %0d: id=%0d", i, e);
    end

    // Zero amount: 1001 returned next cycle
    req0_valid = 1'b1; req0_data = 4'b1001; req0_amt = 3'd0; req0_dir = 1'b0;
    #1 chk_rdy("zero.T", 1'b1, 1'b0);
    step(); req0_valid = 1'b0; #1;
    chk_rsp("zero.T1", 1'b1, 4'b1001, 1'b0);
    step();
    $display("zero amount: data=%b", 4'b1001);

    // Over-range amount 5 on 4 bits: zero, and no response before T+6
    req0_valid = 1'b1; req0_data = 4'b1111; req0_amt = 3'd5; req0_dir = 1'b0;
    #1 chk_rdy("ovr.T", 1'b1, 1'b0);
    step(); req0_valid = 1'b0; #1;
    for (int k = 1; k <= 5; k++) begin
      chk("ovr.early", {7'd0, rsp_valid}, 8'd0);
      if (k < 5) step();
    end
    step();
    chk_rsp("ovr.T6", 1'b1, 4'b0000, 1'b0);
    step();
    $display("over-range: data=%b", 4'b0000);

    // Backpressure: 0011 << 1 = 0110 held while rsp_ready=0, req1 waiting
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 4'b0011; req0_amt = 3'd1; req0_dir = 1'b0;
    #1 chk_rdy("bp.T", 1'b1, 1'b0);
    step(); req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 4'b1100; req1_amt = 3'd0; req1_dir = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk_rsp("bp.hold", 1'b1, 4'b0110, 1'b0);
      chk_busy("bp.hold", 1'b1);
      chk_rdy("bp.hold", 1'b0, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk_rsp("bp.hs", 1'b1, 4'b0110, 1'b0);
    chk_rdy("bp.hs", 1'b0, 1'b0);
    step();
    chk_rdy("bp.next", 1'b0, 1'b1);
    step(); req1_valid = 1'b0; #1;
    chk_rsp("bp.r1", 1'b1, 4'b1100, 1'b1);
    step();
    $display("backpressure: held data=%b, then id=1 data=%b", 4'b0110, 4'b1100);

    // Reset mid-shift: outputs drop at once, no response, tie goes to 0
    req0_valid = 1'b1; req0_data = 4'b1111; req0_amt = 3'd6; req0_dir = 1'b1;
    #1 chk_rdy("mrst.T", 1'b1, 1'b0);
    step(); req0_valid = 1'b0;
    step(); step();
    chk_busy("mrst.T3", 1'b1);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk_rsp("mrst.in", 1'b0, 4'b0000, 1'b0);
    chk_busy("mrst.in", 1'b0);
    chk_rdy("mrst.in", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk_rsp("mrst.out", 1'b0, 4'b0000, 1'b0);
    chk_busy("mrst.out", 1'b0);
    chk_rdy("mrst.tie", 1'b1, 1'b0);
    $display("reset mid-shift: discarded, tie grants id=0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that shares a single one-position shift step between two requesters. Each request carries a data word, a shift amount and a direction. The block arbitrates round-robin, accepts one request at a time and applies one logical shift per clock until the amount is exhausted. It then returns the result on a valid/ready response channel tagged with the requester ID. It sits between the requesting units and the logical-shift datapath in the arithmetic section of the design.

## Interface
- `WIDTH`, default 4: data word width.
- `AW`, default 3: shift-amount width; amounts 0..2^AW-1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a request.
- `req0_ready`  out  1  requester 0 request accepted this cycle.
- `req0_data`  in  WIDTH  operand.
- `req0_amt`  in  AW  shift amount.
- `req0_dir`  in  1  0 = shift left, 1 = shift right.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_amt`, `req1_dir`: same as requester 0, for requester 1.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  WIDTH  shifted result.
- `rsp_id`  out  1  requester that owns the result.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states and transitions:
  - **IDLE**: wait for a request. On accept, go to SHIFT if the loaded amount is nonzero, otherwise to DONE.
  - **SHIFT**: one step per cycle. Go to DONE on the cycle in which the count decrements from 1 to 0.
  - **DONE**: hold `rsp_valid`=1. Go to IDLE on the cycle where `rsp_valid && rsp_ready`.
- Arbitration, evaluated only in IDLE:
  - A single valid requester is granted.
  - If both are valid, grant the requester not served last.
  - The `last_id` register resets to 1, so requester 0 wins the first tie.
  - `last_id` updates only on accept.
- Ready outputs:
  - `reqN_ready` = IDLE && grant==N && `reqN_valid`. It is combinational.
  - At most one ready is high in any cycle.
  - Both readys are 0 outside IDLE and while `rst_n`=0.
- Accept (`reqN_valid && reqN_ready`) loads the registers: `acc` ← data, `cnt` ← amt, `dir`, `id` ← N.
- SHIFT step:
  - `acc` ← `dir` ? `acc`>>1 : `acc`<<1, truncated to WIDTH bits and zero-filled.
  - `cnt` ← `cnt`-1.
- Results:
  - An amount ≥ WIDTH yields 0 but still takes `amt` cycles; there is no early exit.
  - `rsp_data`=`acc` and `rsp_id`=`id` are valid only in DONE.
  - `rsp_data`, `rsp_id` and `rsp_valid` are stable while `rsp_valid && !rsp_ready`.
- Request inputs are ignored outside IDLE. A requester keeps `valid` high until it is accepted; the block never drops a presented request.
- Reset values: state IDLE, `acc`=0, `cnt`=0, `id`=0, `last_id`=1. Output values during and after reset:
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0.
  - `req0_ready`=`req1_ready`=0.
- Reset mid-operation: an in-flight request is discarded and no response is issued. Requesters must re-present it.

## Timing
- Accept in cycle T gives `rsp_valid`=1 in cycle T+1+amt (amt=0 gives T+1).
- Response handshake in cycle R gives state IDLE in R+1. The earliest next accept is R+1, so one request is handled per (amt+2) cycles under no backpressure.
- `busy` is high from T+1 through the response handshake cycle R.
- No combinational path from `rsp_ready` to any `reqN_ready`.
- Both valids high in IDLE: exactly one accept; the loser is granted at the next IDLE.

## Test plan
- Single left shift: req0 data=4'b1011, amt=1, dir=0, accepted at T → `rsp_valid` at T+2, `rsp_data`=4'b0110, `rsp_id`=0; `busy` high T+1..T+2.
- Right shift and zero amount: req1 data=4'b1011, amt=2, dir=1 → 4'b0010 at T+3, `rsp_id`=1. Then req0 data=4'b1001, amt=0 → 4'b1001 at T'+1.
- Over-range amount: req0 data=4'b1111, amt=5, dir=0 → `rsp_data`=4'b0000 at T+6 with no early response.
- Round-robin: both requesters continuously valid, amt=1, `rsp_ready`=1 → accept order 0,1,0,1. Each ready is asserted only in an IDLE cycle, and never both at once.
- Backpressure: hold `rsp_ready`=0 for 3 cycles after `rsp_valid` with req1 valid → `rsp_data`/`rsp_id` stable, `busy`=1, `req1_ready`=0. After release, req1 is accepted the cycle after the handshake.
- Reset mid-shift: req0 amt=6, assert `rst_n`=0 at T+3 → all outputs 0 immediately. After release, state IDLE with no response issued, and a fresh tie grants requester 0.
